// File: rtl/merlin_bus_arb32.sv
// Two-port (pre-fetch I / load-store D) to one 32-bit memory bus arbiter with in-order response routing.
// Define MERLIN_BUS_ARB_ROUND_ROBIN_EN for round-robin contention handling; otherwise D has fixed priority.
module merlin_bus_arb32 #(
  parameter int C_OUTSTANDING_X = 1
) (
  input  logic        clk_i,
  input  logic        reset_i,

  output logic        i_reqready_o,
  input  logic        i_reqvalid_i,
  input  logic [1:0]  i_reqhpl_i,
  input  logic [31:0] i_reqaddr_i,
  input  logic        i_rspready_i,
  output logic        i_rspvalid_o,
  output logic        i_rsprerr_o,
  output logic [31:0] i_rspdata_o,

  output logic        d_reqready_o,
  input  logic        d_reqvalid_i,
  input  logic [1:0]  d_reqhpl_i,
  input  logic [31:0] d_reqaddr_i,
  input  logic        d_reqwr_i,
  input  logic [3:0]  d_reqmask_i,
  input  logic [31:0] d_reqwdata_i,
  input  logic        d_rspready_i,
  output logic        d_rspvalid_o,
  output logic        d_rsprerr_o,
  output logic [31:0] d_rspdata_o,

  input  logic        m_reqready_i,
  output logic        m_reqvalid_o,
  output logic [1:0]  m_reqhpl_o,
  output logic [31:0] m_reqaddr_o,
  output logic        m_reqwr_o,
  output logic [3:0]  m_reqmask_o,
  output logic [31:0] m_reqwdata_o,
  output logic        m_rspready_o,
  input  logic        m_rspvalid_i,
  input  logic        m_rsprerr_i,
  input  logic [31:0] m_rspdata_i
);

  localparam int DEPTH = 1 << C_OUTSTANDING_X;
  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;
  localparam logic [C_OUTSTANDING_X-1:0] PTR_ONE = C_OUTSTANDING_X'(1);
  localparam logic [C_OUTSTANDING_X:0]   LVL_ONE = (C_OUTSTANDING_X + 1)'(1);

  logic [DEPTH-1:0]           owner_q;
  logic [C_OUTSTANDING_X-1:0] wr_ptr;
  logic [C_OUTSTANDING_X-1:0] rd_ptr;
  logic [C_OUTSTANDING_X:0]   level;
  logic                       lock_q;
  logic                       lock_port_q;

  logic owner_full;
  logic owner_empty;
  logic head_owner;
  logic policy_grant;
  logic grant;
  logic req_valid;
  logic accept;
  logic pop;

  // Level never exceeds DEPTH, so its top bit alone marks a full FIFO.
  assign owner_full  = level[C_OUTSTANDING_X];
  assign owner_empty = (level == '0);
  assign head_owner  = owner_q[rd_ptr];

`ifdef MERLIN_BUS_ARB_ROUND_ROBIN_EN
  logic last_q;

  assign policy_grant = ~last_q;

  // Remember who won the last accepted request; reset value makes D win first.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      last_q <= OWN_I;
    end else if (accept) begin
      last_q <= grant;
    end
  end
`else
  assign policy_grant = OWN_D;
`endif

  always_comb begin
    grant = OWN_D;
    if (lock_q) begin
      grant = lock_port_q;
    end else if (i_reqvalid_i && !d_reqvalid_i) begin
      grant = OWN_I;
    end else if (d_reqvalid_i && !i_reqvalid_i) begin
      grant = OWN_D;
    end else if (i_reqvalid_i && d_reqvalid_i) begin
      grant = policy_grant;
    end
  end

  assign req_valid    = reset_i & (grant ? d_reqvalid_i : i_reqvalid_i) & ~owner_full;
  assign accept       = req_valid & m_reqready_i;
  assign m_reqvalid_o = req_valid;
  assign i_reqready_o = reset_i & ~grant & m_reqready_i & ~owner_full;
  assign d_reqready_o = reset_i &  grant & m_reqready_i & ~owner_full;

  assign m_reqhpl_o   = grant ? d_reqhpl_i   : i_reqhpl_i;
  assign m_reqaddr_o  = grant ? d_reqaddr_i  : i_reqaddr_i;
  assign m_reqwr_o    = grant & d_reqwr_i;
  assign m_reqmask_o  = grant ? d_reqmask_i  : 4'hF;
  assign m_reqwdata_o = grant ? d_reqwdata_i : 32'h0;

  assign m_rspready_o = reset_i & ~owner_empty & (head_owner ? d_rspready_i : i_rspready_i);
  assign pop          = m_rspvalid_i & m_rspready_o;
  assign i_rspvalid_o = reset_i & m_rspvalid_i & ~owner_empty & ~head_owner;
  assign d_rspvalid_o = reset_i & m_rspvalid_i & ~owner_empty &  head_owner;
  assign i_rsprerr_o  = m_rsprerr_i;
  assign d_rsprerr_o  = m_rsprerr_i;
  assign i_rspdata_o  = m_rspdata_i;
  assign d_rspdata_o  = m_rspdata_i;

  // Owner FIFO bookkeeping plus the stall lock that pins the grant until acceptance.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      lock_q      <= 1'b0;
      lock_port_q <= OWN_D;
    end else begin
      if (accept) begin
        owner_q[wr_ptr] <= grant;
        wr_ptr          <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (accept && !pop) begin
        level <= level + LVL_ONE;
      end else if (pop && !accept) begin
        level <= level - LVL_ONE;
      end
      lock_q      <= req_valid & ~m_reqready_i;
      lock_port_q <= grant;
    end
  end

endmodule

// File: tb/tb_merlin_bus_arb32.sv
// Bench for merlin_bus_arb32: queue-based reference model checked every cycle, plus directed literal checks.
// Honours MERLIN_BUS_ARB_ROUND_ROBIN_EN the same way as the design.
module tb_merlin_bus_arb32;

  localparam int DEPTH = 2;
`ifdef MERLIN_BUS_ARB_ROUND_ROBIN_EN
  localparam bit [3:0] GRANT_SEQ = 4'b0101;
`else
  localparam bit [3:0] GRANT_SEQ = 4'b1111;
`endif

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        i_reqready_o, i_reqvalid_i, i_rspready_i, i_rspvalid_o, i_rsprerr_o;
  logic [1:0]  i_reqhpl_i;
  logic [31:0] i_reqaddr_i, i_rspdata_o;
  logic        d_reqready_o, d_reqvalid_i, d_reqwr_i, d_rspready_i, d_rspvalid_o, d_rsprerr_o;
  logic [1:0]  d_reqhpl_i;
  logic [3:0]  d_reqmask_i;
  logic [31:0] d_reqaddr_i, d_reqwdata_i, d_rspdata_o;
  logic        m_reqready_i, m_reqvalid_o, m_reqwr_o, m_rspready_o, m_rspvalid_i, m_rsprerr_i;
  logic [1:0]  m_reqhpl_o;
  logic [3:0]  m_reqmask_o;
  logic [31:0] m_reqaddr_o, m_reqwdata_o, m_rspdata_i;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: owners of outstanding requests, last accepted port, stall lock.
  bit mdl_q[$];
  bit mdl_last = 1'b0;
  bit mdl_lock = 1'b0;
  bit mdl_lock_port = 1'b0;
  bit e_grant, e_any_req, e_mreqvalid, e_ireqready, e_dreqready;
  bit e_mrspready, e_irspvalid, e_drspvalid;

  merlin_bus_arb32 #(.C_OUTSTANDING_X(1)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .i_reqready_o(i_reqready_o), .i_reqvalid_i(i_reqvalid_i), .i_reqhpl_i(i_reqhpl_i),
    .i_reqaddr_i(i_reqaddr_i), .i_rspready_i(i_rspready_i), .i_rspvalid_o(i_rspvalid_o),
    .i_rsprerr_o(i_rsprerr_o), .i_rspdata_o(i_rspdata_o),
    .d_reqready_o(d_reqready_o), .d_reqvalid_i(d_reqvalid_i), .d_reqhpl_i(d_reqhpl_i),
    .d_reqaddr_i(d_reqaddr_i), .d_reqwr_i(d_reqwr_i), .d_reqmask_i(d_reqmask_i),
    .d_reqwdata_i(d_reqwdata_i), .d_rspready_i(d_rspready_i), .d_rspvalid_o(d_rspvalid_o),
    .d_rsprerr_o(d_rsprerr_o), .d_rspdata_o(d_rspdata_o),
    .m_reqready_i(m_reqready_i), .m_reqvalid_o(m_reqvalid_o), .m_reqhpl_o(m_reqhpl_o),
    .m_reqaddr_o(m_reqaddr_o), .m_reqwr_o(m_reqwr_o), .m_reqmask_o(m_reqmask_o),
    .m_reqwdata_o(m_reqwdata_o), .m_rspready_o(m_rspready_o), .m_rspvalid_i(m_rspvalid_i),
    .m_rsprerr_i(m_rsprerr_i), .m_rspdata_i(m_rspdata_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_eval();
    bit full;
    bit empty;
    bit head;
    full  = (mdl_q.size() == DEPTH);
    empty = (mdl_q.size() == 0);
    head  = empty ? 1'b0 : mdl_q[0];
    e_any_req = i_reqvalid_i | d_reqvalid_i;
    if (mdl_lock)                          e_grant = mdl_lock_port;
    else if (i_reqvalid_i && !d_reqvalid_i) e_grant = 1'b0;
    else if (d_reqvalid_i && !i_reqvalid_i) e_grant = 1'b1;
`ifdef MERLIN_BUS_ARB_ROUND_ROBIN_EN
    else                                   e_grant = !mdl_last;
`else
    else                                   e_grant = 1'b1;
`endif
    e_mreqvalid = reset_i && !full && (e_grant ? d_reqvalid_i : i_reqvalid_i);
    e_ireqready = reset_i && !full && m_reqready_i && !e_grant;
    e_dreqready = reset_i && !full && m_reqready_i &&  e_grant;
    e_mrspready = reset_i && !empty && (head ? d_rspready_i : i_rspready_i);
    e_irspvalid = reset_i && m_rspvalid_i && !empty && !head;
    e_drspvalid = reset_i && m_rspvalid_i && !empty &&  head;
  endfunction

  // Advance the model on each rising edge using the inputs the design also sees.
  always @(posedge clk_i) begin
    model_eval();
    if (!reset_i) begin
      mdl_q.delete();
      mdl_last = 1'b0;
      mdl_lock = 1'b0;
    end else begin
      if (e_mrspready && m_rspvalid_i) void'(mdl_q.pop_front());
      if (e_mreqvalid && m_reqready_i) begin
        mdl_q.push_back(e_grant);
        mdl_last = e_grant;
      end
      mdl_lock      = e_mreqvalid && !m_reqready_i;
      mdl_lock_port = e_grant;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk_i) begin
    model_eval();
    check_output("m_reqvalid", 32'(m_reqvalid_o), 32'(e_mreqvalid));
    if (!reset_i || e_any_req) begin
      check_output("i_reqready", 32'(i_reqready_o), 32'(e_ireqready));
      check_output("d_reqready", 32'(d_reqready_o), 32'(e_dreqready));
    end
    check_output("m_rspready", 32'(m_rspready_o), 32'(e_mrspready));
    check_output("i_rspvalid", 32'(i_rspvalid_o), 32'(e_irspvalid));
    check_output("d_rspvalid", 32'(d_rspvalid_o), 32'(e_drspvalid));
    if (e_mreqvalid) begin
      check_output("m_reqaddr",  m_reqaddr_o, e_grant ? d_reqaddr_i : i_reqaddr_i);
      check_output("m_reqhpl",   32'(m_reqhpl_o), 32'(e_grant ? d_reqhpl_i : i_reqhpl_i));
      check_output("m_reqwr",    32'(m_reqwr_o), 32'(e_grant ? d_reqwr_i : 1'b0));
      check_output("m_reqmask",  32'(m_reqmask_o), 32'(e_grant ? d_reqmask_i : 4'hF));
      check_output("m_reqwdata", m_reqwdata_o, e_grant ? d_reqwdata_i : 32'h0);
    end
    if (e_irspvalid) begin
      check_output("i_rspdata", i_rspdata_o, m_rspdata_i);
      check_output("i_rsprerr", 32'(i_rsprerr_o), 32'(m_rsprerr_i));
    end
    if (e_drspvalid) begin
      check_output("d_rspdata", d_rspdata_o, m_rspdata_i);
      check_output("d_rsprerr", 32'(d_rsprerr_o), 32'(m_rsprerr_i));
    end
  end

  task automatic apply_stimulus(input bit iv, input logic [31:0] ia, input bit dv,
                                input logic [31:0] da, input bit mready);
    i_reqvalid_i = iv;
    i_reqaddr_i  = ia;
    d_reqvalid_i = dv;
    d_reqaddr_i  = da;
    m_reqready_i = mready;
  endtask

  task automatic apply_response(input bit valid, input logic [31:0] data, input bit rerr,
                                input bit irr, input bit drr);
    m_rspvalid_i = valid;
    m_rspdata_i  = data;
    m_rsprerr_i  = rerr;
    i_rspready_i = irr;
    d_rspready_i = drr;
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk_i);
      next_cycle();
    end
  endtask

  initial begin
    reset_i      = 1'b0;
    i_reqhpl_i   = 2'd1;
    d_reqhpl_i   = 2'd3;
    d_reqwr_i    = 1'b1;
    d_reqmask_i  = 4'h3;
    d_reqwdata_i = 32'h1122_3344;
    apply_stimulus(1'b1, 32'h100, 1'b1, 32'h300, 1'b1);
    apply_response(1'b1, 32'h0, 1'b0, 1'b1, 1'b1);

    // Reset holds every handshake output low even with live inputs.
    @(negedge clk_i);
    check_output("rst_m_reqvalid", 32'(m_reqvalid_o), 32'd0);
    check_output("rst_i_reqready", 32'(i_reqready_o), 32'd0);
    check_output("rst_d_reqready", 32'(d_reqready_o), 32'd0);
    check_output("rst_m_rspready", 32'(m_rspready_o), 32'd0);
    check_output("rst_i_rspvalid", 32'(i_rspvalid_o), 32'd0);
    next_cycle();
    next_cycle();

    reset_i = 1'b1;
    apply_stimulus(1'b1, 32'h100, 1'b0, 32'h300, 1'b1);
    apply_response(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk_i);
    check_output("t1_m_reqaddr",  m_reqaddr_o, 32'h100);
    check_output("t1_m_reqmask",  32'(m_reqmask_o), 32'hF);
    check_output("t1_i_reqready", 32'(i_reqready_o), 32'd1);
    check_output("t1_m_reqvalid", 32'(m_reqvalid_o), 32'd1);
    next_cycle();
    apply_stimulus(1'b0, 32'h100, 1'b0, 32'h300, 1'b1);
    idle_cycles(1);
    apply_response(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0);
    @(negedge clk_i);
    check_output("t1_i_rspvalid", 32'(i_rspvalid_o), 32'd1);
    check_output("t1_d_rspvalid", 32'(d_rspvalid_o), 32'd0);
    check_output("t1_i_rspdata",  i_rspdata_o, 32'hDEAD_BEEF);
    next_cycle();
    apply_response(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

    // Contention: four back-to-back accepted requests.
    apply_stimulus(1'b1, 32'h200, 1'b1, 32'h300, 1'b1);
    apply_response(1'b1, 32'h0BAD_F00D, 1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i);
      check_output($sformatf("t2_d_reqready_%0d", k), 32'(d_reqready_o), 32'(GRANT_SEQ[k]));
      check_output($sformatf("t2_i_reqready_%0d", k), 32'(i_reqready_o), 32'(!GRANT_SEQ[k]));
      check_output($sformatf("t2_m_reqaddr_%0d", k), m_reqaddr_o,
                   GRANT_SEQ[k] ? 32'h300 : 32'h200);
      next_cycle();
    end
    apply_stimulus(1'b0, 32'h200, 1'b0, 32'h300, 1'b1);
    idle_cycles(2);
    apply_response(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

    // D stalled by memory while I also waits: grant and fields stay on D.
    apply_stimulus(1'b1, 32'h200, 1'b1, 32'h300, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      check_output("t3_m_reqaddr",   m_reqaddr_o, 32'h300);
      check_output("t3_m_reqwdata",  m_reqwdata_o, 32'h1122_3344);
      check_output("t3_d_reqready",  32'(d_reqready_o), 32'd0);
      next_cycle();
    end
    m_reqready_i = 1'b1;
    @(negedge clk_i);
    check_output("t3_accept_d", 32'(d_reqready_o), 32'd1);
    check_output("t3_accept_i", 32'(i_reqready_o), 32'd0);
    next_cycle();

    // A stalled I grant keeps the bus even after D starts competing.
    apply_stimulus(1'b1, 32'h240, 1'b0, 32'h300, 1'b0);
    @(negedge clk_i);
    check_output("t3b_m_reqaddr", m_reqaddr_o, 32'h240);
    next_cycle();
    d_reqvalid_i = 1'b1;
    @(negedge clk_i);
    check_output("t3b_lock_addr", m_reqaddr_o, 32'h240);
    next_cycle();
    m_reqready_i = 1'b1;
    @(negedge clk_i);
    check_output("t3b_i_reqready", 32'(i_reqready_o), 32'd1);
    check_output("t3b_d_reqready", 32'(d_reqready_o), 32'd0);
    next_cycle();
    apply_stimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    apply_response(1'b1, 32'h1234_5678, 1'b0, 1'b1, 1'b1);
    idle_cycles(3);
    apply_response(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

    // Owner FIFO full: third request waits; a same-cycle pop does not unblock it.
    apply_stimulus(1'b1, 32'h400, 1'b0, 32'h0, 1'b1);
    @(negedge clk_i);
    check_output("t4_first",  32'(i_reqready_o), 32'd1);
    next_cycle();
    @(negedge clk_i);
    check_output("t4_second", 32'(i_reqready_o), 32'd1);
    next_cycle();
    @(negedge clk_i);
    check_output("t4_full_ready", 32'(i_reqready_o), 32'd0);
    check_output("t4_full_valid", 32'(m_reqvalid_o), 32'd0);
    next_cycle();
    apply_response(1'b1, 32'hCAFE_0001, 1'b0, 1'b1, 1'b0);
    @(negedge clk_i);
    check_output("t4_pop_ready",  32'(i_reqready_o), 32'd0);
    check_output("t4_pop_rsprdy", 32'(m_rspready_o), 32'd1);
    next_cycle();
    @(negedge clk_i);
    check_output("t4_after_pop", 32'(i_reqready_o), 32'd1);
    next_cycle();
    apply_stimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    idle_cycles(3);
    apply_response(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

    // In-order responses: I head blocks D until I is ready.
    d_reqwr_i = 1'b0;
    apply_stimulus(1'b1, 32'h500, 1'b0, 32'h0, 1'b1);
    idle_cycles(1);
    apply_stimulus(1'b0, 32'h500, 1'b1, 32'h600, 1'b1);
    @(negedge clk_i);
    check_output("t5_d_reqready", 32'(d_reqready_o), 32'd1);
    next_cycle();
    apply_stimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    apply_response(1'b1, 32'hAAAA_5555, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk_i);
      check_output("t5_hold_rspready", 32'(m_rspready_o), 32'd0);
      check_output("t5_hold_i_valid",  32'(i_rspvalid_o), 32'd1);
      check_output("t5_hold_d_valid",  32'(d_rspvalid_o), 32'd0);
      next_cycle();
    end
    i_rspready_i = 1'b1;
    @(negedge clk_i);
    check_output("t5_i_rspready", 32'(m_rspready_o), 32'd1);
    check_output("t5_i_rspdata",  i_rspdata_o, 32'hAAAA_5555);
    next_cycle();
    apply_response(1'b1, 32'h5555_AAAA, 1'b1, 1'b1, 1'b1);
    @(negedge clk_i);
    check_output("t5_d_rspvalid", 32'(d_rspvalid_o), 32'd1);
    check_output("t5_d_i_valid",  32'(i_rspvalid_o), 32'd0);
    check_output("t5_d_rsprerr",  32'(d_rsprerr_o), 32'd1);
    next_cycle();
    @(negedge clk_i);
    check_output("t5_empty_rspready", 32'(m_rspready_o), 32'd0);
    check_output("t5_empty_d_valid",  32'(d_rspvalid_o), 32'd0);
    next_cycle();
    apply_response(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

    // Reset with two requests outstanding drops them.
    apply_stimulus(1'b1, 32'h700, 1'b0, 32'h0, 1'b1);
    idle_cycles(1);
    apply_stimulus(1'b0, 32'h700, 1'b1, 32'h800, 1'b1);
    idle_cycles(1);
    reset_i = 1'b0;
    apply_stimulus(1'b1, 32'h700, 1'b0, 32'h800, 1'b1);
    apply_response(1'b1, 32'h0, 1'b0, 1'b1, 1'b1);
    @(negedge clk_i);
    check_output("t6_rst_m_reqvalid", 32'(m_reqvalid_o), 32'd0);
    check_output("t6_rst_m_rspready", 32'(m_rspready_o), 32'd0);
    check_output("t6_rst_i_rspvalid", 32'(i_rspvalid_o), 32'd0);
    next_cycle();
    reset_i = 1'b1;
    apply_stimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    @(negedge clk_i);
    check_output("t6_post_m_rspready", 32'(m_rspready_o), 32'd0);
    check_output("t6_post_i_rspvalid", 32'(i_rspvalid_o), 32'd0);
    check_output("t6_post_d_rspvalid", 32'(d_rspvalid_o), 32'd0);
    next_cycle();
    apply_response(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    idle_cycles(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/merlin_bus_arb32.md
Name: merlin_bus_arb32

Overview:
- Shares one 32-bit memory bus between the instruction pre-fetch port (port I) and the load/store port (port D).
- Arbitrates the request channel and records the owner of every accepted request in an in-order owner FIFO.
- Routes each memory response back to the port that issued it.
- Sits between the core (pre-fetch unit, LSU) and the single external memory/cache bus.

Parameters:
C_OUTSTANDING_X, 1, log2 of the maximum number of accepted-but-unanswered memory requests (owner FIFO depth 2**C_OUTSTANDING_X)

Ports:
clk_i  in  1  clock
reset_i  in  1  synchronous reset, active-low
i_reqready_o  out  1  port I request accepted
i_reqvalid_i  in  1  port I request valid
i_reqhpl_i  in  2  port I privilege level
i_reqaddr_i  in  32  port I address
i_rspready_i  in  1  port I response ready
i_rspvalid_o  out  1  port I response valid
i_rsprerr_o  out  1  port I response error
i_rspdata_o  out  32  port I response data
d_reqready_o  out  1  port D request accepted
d_reqvalid_i  in  1  port D request valid
d_reqhpl_i  in  2  port D privilege level
d_reqaddr_i  in  32  port D address
d_reqwr_i  in  1  port D write (1) / read (0)
d_reqmask_i  in  4  port D byte mask
d_reqwdata_i  in  32  port D write data
d_rspready_i  in  1  port D response ready
d_rspvalid_o  out  1  port D response valid
d_rsprerr_o  out  1  port D response error
d_rspdata_o  out  32  port D response data
m_reqready_i  in  1  memory accepts request
m_reqvalid_o  out  1  memory request valid
m_reqhpl_o  out  2  granted hpl
m_reqaddr_o  out  32  granted address
m_reqwr_o  out  1  write flag (0 for port I)
m_reqmask_o  out  4  byte mask (4'hF for port I)
m_reqwdata_o  out  32  write data (0 for port I)
m_rspready_o  out  1  response ready to memory
m_rspvalid_i  in  1  memory response valid
m_rsprerr_i  in  1  memory response error
m_rspdata_i  in  32  memory response data

Behaviour:
- Reset (reset_i==0 at a clk_i edge):
  - Owner FIFO emptied, grant lock cleared, round-robin pointer set to favour D.
  - While in reset, all *valid_o/*ready_o are 0.
- Request path is combinational, zero added latency.
  - m_reqvalid_o = granted port valid & ~owner_full.
  - Request fields muxed from the granted port.
  - Only the granted port's reqready_o = m_reqready_i & ~owner_full; the other port's reqready_o = 0.
- Grant selection:
  - Only I valid -> I. Only D valid -> D.
  - Both valid -> arbitration policy (see Optional Feature).
- Grant lock:
  - If m_reqvalid_o=1 and m_reqready_i=0, the lock register holds the current grant.
  - Next cycle the same port is granted regardless of policy; the lock clears on acceptance.
  - A requester must hold valid and fields stable until accepted.
- Owner FIFO:
  - Push the owner bit (0=I, 1=D) on m_reqvalid_o & m_reqready_i.
  - Pop on m_rspvalid_i & m_rspready_o.
  - Pointers wrap modulo depth; level counter is C_OUTSTANDING_X+1 bits.
- Full: new requests are blocked even if a pop occurs in the same cycle (no ready-to-ready combinational path).
- Push and pop in the same cycle: level is unchanged.
- Response path:
  - m_rspready_o = ~owner_empty & rspready of the head owner.
  - Head owner's rspvalid_o = m_rspvalid_i & ~owner_empty; the other port's rspvalid_o = 0.
  - rerr/data broadcast to both ports; only meaningful where valid.
  - Responses are strictly in request order.
- Response while owner FIFO empty: m_rspready_o=0 (stalled, never dropped).

Optional Feature:
- Macro MERLIN_BUS_ARB_ROUND_ROBIN_EN.
- Defined: on contention, grant the port not granted by the last accepted request. The pointer updates only on request acceptance.
- Undefined: fixed priority, D always wins contention; pointer logic absent.
- Lock and all other behaviour are identical in both builds.

Test Plan:
- Reset low 2 cycles, then I valid addr 0x100, m_reqready_i=1 -> m_reqaddr_o=0x100, m_reqmask_o=4'hF, i_reqready_o=1 same cycle; response data 0xDEADBEEF two cycles later -> i_rspvalid_o=1, d_rspvalid_o=0.
- I and D both valid for 4 accepted cycles -> RR build grants D,I,D,I; fixed build grants D,D,D,D.
- D granted with m_reqready_i=0 for 3 cycles while I also valid -> grant stays D, fields stable, then accepted in cycle 4.
- C_OUTSTANDING_X=1, m_rspvalid_i=0, I issues 3 requests -> first 2 accepted, 3rd sees i_reqready_o=0 until the first response pops.
- Issue I then D; return responses with d_rspready_i=1, i_rspready_i=0 -> m_rspready_o=0 (head is I); set i_rspready_i=1 -> I then D delivered in order.
- Assert reset_i=0 with 2 outstanding requests -> next cycle FIFO empty, all valid/ready outputs 0.
